// File: rtl/lz77_stream_encoder.sv
// rtl/lz77_stream_encoder.sv - streaming LZ77 encoder emitting (offset, len, char) tuples
// Optional macro LZ77_EARLY_EXIT_EN ends SEARCH once the best match reaches its cap.
module lz77_stream_encoder #(
    parameter int         SYM_W        = 4,
    parameter int         SEARCH_DEPTH = 9,
    parameter int         LOOK_DEPTH   = 8,
    parameter logic [7:0] EOS_CHAR     = 8'h24,
    localparam int        OFF_W        = $clog2(SEARCH_DEPTH),
    localparam int        LEN_W        = $clog2(LOOK_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OFF_W-1:0] out_offset,
    output logic [LEN_W-1:0] out_len,
    output logic [7:0]       out_char,
    output logic             out_eos,
    output logic             finish
);

    localparam logic [LEN_W:0]   LA_FULL   = (LEN_W+1)'(LOOK_DEPTH);
    localparam logic [LEN_W:0]   LEN_MAX   = (LEN_W+1)'(LOOK_DEPTH - 1);
    localparam logic [OFF_W:0]   HIST_FULL = (OFF_W+1)'(SEARCH_DEPTH);
    localparam logic [OFF_W-1:0] CAND_TOP  = OFF_W'(SEARCH_DEPTH - 1);

    typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_t;

    state_t           state;
    logic [SYM_W-1:0] search_buf [SEARCH_DEPTH];
    logic [SYM_W-1:0] la_buf     [LOOK_DEPTH];
    logic [LEN_W:0]   la_cnt;
    logic [OFF_W:0]   hist_cnt;
    logic             last_seen;
    logic [OFF_W-1:0] cand;
    logic [OFF_W-1:0] best_off;
    logic [LEN_W-1:0] best_len;
    logic [LEN_W:0]   shift_cnt;

    logic [LEN_W:0]   cap;
    logic [LEN_W:0]   cand_len;
    logic             run;
    logic [SYM_W-1:0] ref_sym;
    logic             cand_ok;
    logic             better;
    logic [LEN_W-1:0] nb_len;
    logic [OFF_W-1:0] nb_off;
    logic             nb_eos;
    logic [7:0]       nb_char;
    logic             search_end;

    // Candidate k reaches back into history first, then wraps into the
    // lookahead itself, which is what lets a match overlap its own source.
    always_comb begin
        cap      = (la_cnt < LEN_MAX) ? la_cnt : LEN_MAX;
        cand_len = '0;
        run      = 1'b1;
        ref_sym  = '0;
        for (int j = 0; j < LOOK_DEPTH - 1; j++) begin
            if (j <= int'(cand))
                ref_sym = search_buf[OFF_W'(int'(cand) - j)];
            else
                ref_sym = la_buf[LEN_W'(j - int'(cand) - 1)];
            if (run && (la_buf[LEN_W'(j)] == ref_sym) && ((LEN_W+1)'(j) < cap))
                cand_len = cand_len + (LEN_W+1)'(1);
            else
                run = 1'b0;
        end
        cand_ok = ({1'b0, cand} < hist_cnt);
        better  = cand_ok && (cand_len > {1'b0, best_len});
        nb_len  = better ? cand_len[LEN_W-1:0] : best_len;
        nb_off  = better ? cand : best_off;
`ifdef LZ77_EARLY_EXIT_EN
        search_end = (cand == '0) || ({1'b0, nb_len} == cap);
`else
        search_end = (cand == '0);
`endif
        nb_eos  = ({1'b0, nb_len} >= la_cnt);
        nb_char = nb_eos ? EOS_CHAR : 8'(la_buf[nb_len]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FILL;
            la_cnt     <= '0;
            hist_cnt   <= '0;
            last_seen  <= 1'b0;
            cand       <= '0;
            best_off   <= '0;
            best_len   <= '0;
            shift_cnt  <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_offset <= '0;
            out_len    <= '0;
            out_char   <= '0;
            out_eos    <= 1'b0;
            finish     <= 1'b0;
            for (int i = 0; i < SEARCH_DEPTH; i++) search_buf[i] <= '0;
            for (int i = 0; i < LOOK_DEPTH; i++) la_buf[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (la_cnt == LA_FULL || last_seen) begin
                        state    <= SEARCH;
                        in_ready <= 1'b0;
                        cand     <= CAND_TOP;
                        best_off <= '0;
                        best_len <= '0;
                    end else if (in_valid && in_ready) begin
                        la_buf[la_cnt[LEN_W-1:0]] <= in_data;
                        la_cnt    <= la_cnt + (LEN_W+1)'(1);
                        last_seen <= in_last;
                        in_ready  <= ((la_cnt + (LEN_W+1)'(1)) < LA_FULL) && !in_last;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SEARCH: begin
                    best_off <= nb_off;
                    best_len <= nb_len;
                    cand     <= cand - OFF_W'(1);
                    if (search_end) begin
                        state      <= EMIT;
                        out_valid  <= 1'b1;
                        out_offset <= nb_off;
                        out_len    <= nb_len;
                        out_char   <= nb_char;
                        out_eos    <= nb_eos;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Shifting after the EOS tuple would be invisible, so go straight to DONE.
                        if (out_eos) begin
                            state  <= DONE;
                            finish <= 1'b1;
                        end else begin
                            state     <= SHIFT;
                            shift_cnt <= {1'b0, out_len} + (LEN_W+1)'(1);
                        end
                    end
                end
                SHIFT: begin
                    search_buf[0] <= la_buf[0];
                    for (int i = 1; i < SEARCH_DEPTH; i++) search_buf[i] <= search_buf[i-1];
                    for (int i = 0; i < LOOK_DEPTH - 1; i++) la_buf[i] <= la_buf[i+1];
                    la_cnt    <= la_cnt - (LEN_W+1)'(1);
                    shift_cnt <= shift_cnt - (LEN_W+1)'(1);
                    if (hist_cnt != HIST_FULL) hist_cnt <= hist_cnt + (OFF_W+1)'(1);
                    if (shift_cnt == (LEN_W+1)'(1)) state <= FILL;
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_lz77_stream_encoder.sv
// tb/tb_lz77_stream_encoder.sv - self-checking bench for lz77_stream_encoder
// Reference model treats history+lookahead as one flat stream and searches it directly.
module tb_lz77_stream_encoder;

    localparam int         SD  = 9;
    localparam int         LD  = 8;
    localparam logic [7:0] EOS = 8'h24;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_offset;
    logic [2:0] out_len;
    logic [7:0] out_char;
    logic       out_eos;
    logic       finish;

    int          tests = 0;
    int          fails = 0;
    int          stim[$];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    lz77_stream_encoder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_offset(out_offset), .out_len(out_len), .out_char(out_char),
        .out_eos(out_eos), .finish(finish)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not end, tests=%0d", tests);
        $fatal(1);
    end

    function automatic logic [15:0] pk(input logic e, input int off, input int len, input int ch);
        return {e, 4'(off), 3'(len), 8'(ch)};
    endfunction

    task automatic build_model();
        int n, pos, lac, hist, cap, best, boff, l;
        exp_q.delete();
        n   = stim.size();
        pos = 0;
        forever begin
            lac  = (n - pos < LD) ? n - pos : LD;
            hist = (pos < SD) ? pos : SD;
            cap  = (lac < LD - 1) ? lac : LD - 1;
            best = 0;
            boff = 0;
            for (int k = 0; k < hist; k++) begin
                l = 0;
                while (l < cap && stim[pos - 1 - k + l] == stim[pos + l]) l++;
                if (l > 0 && l >= best) begin
                    best = l;
                    boff = k;
                end
            end
            if (best < lac) begin
                exp_q.push_back(pk(1'b0, boff, best, stim[pos + best]));
                pos += best + 1;
            end else begin
                exp_q.push_back(pk(1'b1, boff, best, EOS));
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_stream(input string name, input int vprob, input int rprob, input int hold,
                              output int lat, output int stalls);
        int idx, cyc, acc_cyc, rise_cyc, viol, n, h;
        logic done, stalled, pvalid;
        logic [15:0] cur, prev, g;
        idx = 0; cyc = 0; acc_cyc = 0; rise_cyc = 0; viol = 0; n = stim.size(); h = hold;
        done = 1'b0; stalled = 1'b0; pvalid = 1'b0; prev = '0; lat = -1; stalls = 0;
        got_q.delete();
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cur = {out_eos, out_offset, out_len, out_char};
            if (stalled && (out_valid !== 1'b1 || cur !== prev)) viol++;
            if (out_valid && in_ready) viol++;
            if (out_valid && !pvalid) rise_cyc = cyc;
            in_valid = (idx < n) && (int'($urandom_range(99)) < vprob);
            in_data  = (idx < n) ? 4'(stim[idx]) : 4'd0;
            in_last  = (idx == n - 1);
            if (out_valid && h > 0) begin
                out_ready = 1'b0;
                h--;
                stalls++;
            end else begin
                out_ready = (int'($urandom_range(99)) < rprob);
            end
            if (in_valid && in_ready) begin
                idx++;
                acc_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(cur);
                if (out_eos) begin
                    done = 1'b1;
                    lat  = rise_cyc - acc_cyc;
                end
            end
            stalled = out_valid && !out_ready;
            prev    = cur;
            pvalid  = out_valid;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s eos_timeout: got %0d tuples, expected %0d", name, got_q.size(), exp_q.size());
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        tests++;
        if (finish !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s done_state: finish=%b out_valid=%b in_ready=%b, expected 1 0 0",
                     name, finish, out_valid, in_ready);
        end
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL %s handshake_rules: %0d violations, expected 0", name, viol);
        end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s tuple_count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 16'hxxxx;
            tests++;
            if (g !== exp_q[i]) begin
                fails++;
                $display("FAIL %s tuple[%0d]: got %h expected %h", name, i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, out_offset, out_len, out_char, out_eos, finish} !== 19'd0) begin
            fails++;
            $display("FAIL reset_values: got %b expected all zero",
                     {in_ready, out_valid, out_offset, out_len, out_char, out_eos, finish});
        end
        reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_early: in_ready=%b expected 0", in_ready);
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_rise: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat, st;
        logic [15:0] want [5];
        want = '{pk(0,0,0,0), pk(0,0,0,1), pk(0,0,0,2), pk(0,0,0,3), pk(1,0,0,EOS)};
        do_reset();
        stim = '{0, 1, 2, 3};
        build_model();
        run_stream("basic", 100, 100, 0, lat, st);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (got_q.size() <= i || got_q[i] !== want[i]) begin
                fails++;
                $display("FAIL basic_const[%0d]: got %h expected %h", i,
                         (got_q.size() > i) ? got_q[i] : 16'hxxxx, want[i]);
            end
        end
    endtask

    task automatic test_repeat();
        int lat, st;
        logic [15:0] want [2];
        want = '{pk(0,0,0,5), pk(0,0,7,5)};
        do_reset();
        stim.delete();
        repeat (10) stim.push_back(5);
        build_model();
        run_stream("repeat", 100, 100, 0, lat, st);
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (got_q.size() <= i || got_q[i] !== want[i]) begin
                fails++;
                $display("FAIL repeat_const[%0d]: got %h expected %h", i,
                         (got_q.size() > i) ? got_q[i] : 16'hxxxx, want[i]);
            end
        end
    endtask

    task automatic test_overlap();
        int lat, st;
        logic [15:0] want [3];
        want = '{pk(0,0,0,3), pk(0,0,0,4), pk(1,1,3,EOS)};
        do_reset();
        stim = '{3, 4, 3, 4, 3};
        build_model();
        run_stream("overlap", 100, 100, 0, lat, st);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q.size() <= i || got_q[i] !== want[i]) begin
                fails++;
                $display("FAIL overlap_const[%0d]: got %h expected %h", i,
                         (got_q.size() > i) ? got_q[i] : 16'hxxxx, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, st;
        do_reset();
        stim = '{6, 2, 6, 2};
        build_model();
        run_stream("backpressure", 100, 100, 5, lat, st);
        tests++;
        if (st != 5) begin
            fails++;
            $display("FAIL backpressure_stall_cycles: got %0d expected 5", st);
        end
    endtask

    task automatic test_early_exit();
        int lat, st, want_lat;
`ifdef LZ77_EARLY_EXIT_EN
        want_lat = 3;
`else
        want_lat = SD + 2;
`endif
        do_reset();
        stim.delete();
        repeat (20) stim.push_back(7);
        build_model();
        run_stream("sevens", 100, 100, 0, lat, st);
        tests++;
        if (lat != want_lat) begin
            fails++;
            $display("FAIL sevens_eos_latency: got %0d expected %0d", lat, want_lat);
        end
    endtask

    task automatic test_reset_in_search();
        int acc, guard, lat, st;
        logic [15:0] want [3];
        want = '{pk(0,0,0,0), pk(0,0,0,1), pk(1,0,0,EOS)};
        do_reset();
        acc = 0; guard = 0;
        while (acc < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b1;
            in_data  = 4'(acc);
            in_last  = 1'b0;
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (acc != 8) begin
            fails++;
            $display("FAIL midreset_fill: accepted %0d expected 8", acc);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if ({in_ready, out_valid, out_offset, out_len, out_char, out_eos, finish} !== 19'd0) begin
            fails++;
            $display("FAIL midreset_async: got %b expected all zero",
                     {in_ready, out_valid, out_offset, out_len, out_char, out_eos, finish});
        end
        @(negedge clk);
        tests++;
        if ({in_ready, out_valid, finish} !== 3'b000) begin
            fails++;
            $display("FAIL midreset_hold: got %b expected 000", {in_ready, out_valid, finish});
        end
        reset = 1'b0;
        stim = '{0, 1};
        build_model();
        run_stream("after_reset", 100, 100, 0, lat, st);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_q.size() <= i || got_q[i] !== want[i]) begin
                fails++;
                $display("FAIL after_reset_const[%0d]: got %h expected %h", i,
                         (got_q.size() > i) ? got_q[i] : 16'hxxxx, want[i]);
            end
        end
    endtask

    task automatic test_random();
        int n, alph, lat, st;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n    = int'($urandom_range(1, 30));
            alph = int'($urandom_range(1, 4));
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(int'($urandom_range(alph - 1)) + 9);
            build_model();
            run_stream($sformatf("random%0d", r), int'($urandom_range(50, 100)),
                       int'($urandom_range(40, 100)), int'($urandom_range(0, 3)), lat, st);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_overlap();
        test_backpressure();
        test_early_exit();
        test_reset_in_search();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
